// File: rtl/seg7_scan_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_encoder
//  Description : Drives a multiplexed, active-low 7-segment display from a
//                packed vector of hex digits. Digits are scanned round-robin
//                with a programmable dwell and a one-cycle blank guard between
//                digits. New values arrive through a valid/ready handshake and
//                only take effect at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_encoder #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int CNT_W      = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame_start
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      c_cnt_last  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      c_idx_last  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_seg_blank = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] c_dig_off   = '1;
    localparam logic [NUM_DIGITS-1:0] c_dig_one   = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [6:0]          r_seg_n;
    logic [NUM_DIGITS-1:0] r_dig_n;
    logic                r_frame_start;
    logic [DATA_W-1:0]   r_display;
    logic [DATA_W-1:0]   r_pending;
    logic                r_pend_v;
    logic                r_load_ready;
    logic                r_loaded;      // display has been committed since reset

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [6:0]          w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_dig_nxt;
    logic                w_fs_nxt;

    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_dwell_end;
    logic                w_commit;
    logic [DATA_W-1:0]   w_disp_nxt;
    logic [IDX_W-1:0]    w_seg_idx;
    logic [3:0]          w_seg_nib;
    logic [6:0]          w_seg_enc;
    logic [NUM_DIGITS-1:0] w_suppress;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;   // F
        endcase
        return seg;
    endfunction

    // Dwell bookkeeping and the frame-boundary commit decision. The commit
    // happens either while blanked or on the edge where the index wraps to 0,
    // so a frame is always drawn from one consistent display value.
    always_comb begin
        w_idx_inc   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        w_dwell_end = (r_state == ST_SCAN) && enable && (r_cnt == c_cnt_last);
        w_commit    = r_pend_v &&
                      ((r_state == ST_BLANK) || (w_dwell_end && (w_idx_inc == '0)));
        w_disp_nxt  = w_commit ? r_pending : r_display;
    end

    // A digit above position 0 is suppressed when it and every higher digit
    // are zero; digit 0 is always shown.
    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign w_suppress[gi] = 1'b0;
        end else begin : g_upper
            assign w_suppress[gi] = (w_disp_nxt[DATA_W-1:4*gi] == '0);
        end
    end

    // Segment pattern for the digit that will be shown after this edge
    // (digit 0 on scan entry, the next index while scanning).
    always_comb begin
        w_seg_idx = (r_state == ST_SCAN) ? w_idx_inc : '0;
        w_seg_nib = w_disp_nxt[{w_seg_idx, 2'b00} +: 4];
        w_seg_enc = (lz_en && w_suppress[w_seg_idx]) ? c_seg_blank : f_enc(w_seg_nib);
    end

    // Scan FSM next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_seg_nxt   = r_seg_n;
        w_dig_nxt   = r_dig_n;
        w_fs_nxt    = 1'b0;
        case (r_state)
            ST_BLANK: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                w_seg_nxt = c_seg_blank;
                w_dig_nxt = c_dig_off;
                if (enable && r_loaded) begin
                    // Enter scanning with digit 0 preloaded behind a guard cycle
                    w_state_nxt = ST_SCAN;
                    w_seg_nxt   = w_seg_enc;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_seg_nxt   = c_seg_blank;
                    w_dig_nxt   = c_dig_off;
                end else if (r_cnt == c_cnt_last) begin
                    // Advance digit; all selects off for one anti-ghost cycle
                    w_cnt_nxt = '0;
                    w_idx_nxt = w_idx_inc;
                    w_seg_nxt = w_seg_enc;
                    w_dig_nxt = c_dig_off;
                    w_fs_nxt  = (w_idx_inc == '0);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == '0) begin
                        w_dig_nxt = ~(c_dig_one << r_idx);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_seg_nxt   = c_seg_blank;
                w_dig_nxt   = c_dig_off;
            end
        endcase
    end

    // Scan state, counters and registered display outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_seg_n       <= c_seg_blank;
            r_dig_n       <= c_dig_off;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_seg_n       <= w_seg_nxt;
            r_dig_n       <= w_dig_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    // Load handshake: capture into pending, release ready after the commit.
    // A commit requires pend_v, which implies ready is low, so capture and
    // commit never coincide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_display    <= '0;
            r_pending    <= '0;
            r_pend_v     <= 1'b0;
            r_load_ready <= 1'b1;
            r_loaded     <= 1'b0;
        end else if (w_commit) begin
            r_display    <= r_pending;
            r_pend_v     <= 1'b0;
            r_load_ready <= 1'b1;
            r_loaded     <= 1'b1;
        end else if (load_valid && r_load_ready) begin
            r_pending    <= load_data;
            r_pend_v     <= 1'b1;
            r_load_ready <= 1'b0;
        end
    end

    assign seg_n       = r_seg_n;
    assign dig_n       = r_dig_n;
    assign frame_start = r_frame_start;
    assign load_ready  = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_encoder
//  Description : Directed, table-driven bench for seg7_scan_encoder with
//                4 digits and a 4-cycle dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_encoder;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 4;
    localparam int CNT_W      = 4;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic        lz_en      = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0000;
    logic        load_ready;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_start;

    int n_vec = 0;
    int n_bad = 0;

    seg7_scan_encoder #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .lz_en       (lz_en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          rep;
        logic        en;
        logic        lz;
        logic        lv;
        logic [15:0] data;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        rdy;
        logic        fs;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int rep, input logic en, input logic lz,
                                input logic lv, input logic [15:0] data,
                                input logic [6:0] seg, input logic [3:0] dig,
                                input logic rdy, input logic fs);
        vec_t v;
        v.rep = rep; v.en = en; v.lz = lz; v.lv = lv; v.data = data;
        v.seg = seg; v.dig = dig; v.rdy = rdy; v.fs = fs;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [6:0] seg, input logic [3:0] dig,
                         input logic rdy, input logic fs);
        n_vec++;
        if (seg_n !== seg || dig_n !== dig || load_ready !== rdy || frame_start !== fs) begin
            n_bad++;
            $display("FAIL %s: got seg_n=%h dig_n=%h load_ready=%b frame_start=%b, want seg_n=%h dig_n=%h load_ready=%b frame_start=%b",
                     name, seg_n, dig_n, load_ready, frame_start, seg, dig, rdy, fs);
        end
    endtask

    // Drive inputs, take one clock edge, check registered outputs 1 time unit later
    task automatic cyc(input string name, input logic en, input logic lz, input logic lv,
                       input logic [15:0] data, input logic [6:0] seg, input logic [3:0] dig,
                       input logic rdy, input logic fs);
        enable     = en;
        lz_en      = lz;
        load_valid = lv;
        load_data  = data;
        @(posedge clock);
        #1;
        check(name, seg, dig, rdy, fs);
    endtask

    initial begin
        //   rep en lz lv data      seg    dig   rdy fs
        // No load yet: enable alone keeps the display dark
        add(2, 1, 0, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        // Load 4321 while blank; commits one cycle later, scan starts after
        add(1, 1, 0, 1, 16'h4321, 7'h7F, 4'hF, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h79, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h79, 4'hE, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h24, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h24, 4'hD, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h30, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h30, 4'hB, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h19, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h19, 4'h7, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h79, 4'hF, 1, 1);
        add(1, 1, 0, 0, 16'h0000, 7'h79, 4'hE, 1, 0);
        // Mid-frame load of 8888; a second request with FFFF must be ignored
        add(1, 1, 0, 1, 16'h8888, 7'h79, 4'hE, 0, 0);
        add(1, 1, 0, 1, 16'hFFFF, 7'h79, 4'hE, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h24, 4'hF, 0, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h24, 4'hD, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h30, 4'hF, 0, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h30, 4'hB, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h19, 4'hF, 0, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h19, 4'h7, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h00, 4'hF, 1, 1);
        add(3, 1, 0, 0, 16'h0000, 7'h00, 4'hE, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h00, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h00, 4'hD, 1, 0);
        // Leading-zero suppression with 0050
        add(1, 1, 1, 1, 16'h0050, 7'h00, 4'hF, 0, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h00, 4'hB, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h00, 4'hF, 0, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h00, 4'h7, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h40, 4'hF, 1, 1);
        add(3, 1, 1, 0, 16'h0000, 7'h40, 4'hE, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h12, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h12, 4'hD, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'hB, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'h7, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h40, 4'hF, 1, 1);
        // All-zero load: only digit 0 lit
        add(1, 1, 1, 1, 16'h0000, 7'h40, 4'hE, 0, 0);
        add(2, 1, 1, 0, 16'h0000, 7'h40, 4'hE, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h12, 4'hF, 0, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h12, 4'hD, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 0, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'hB, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 0, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'h7, 0, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h40, 4'hF, 1, 1);
        add(3, 1, 1, 0, 16'h0000, 7'h40, 4'hE, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'hD, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'hB, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(3, 1, 1, 0, 16'h0000, 7'h7F, 4'h7, 1, 0);
        add(1, 1, 1, 0, 16'h0000, 7'h40, 4'hF, 1, 1);
        // Disable at start of digit 0, then re-enable with suppression off
        add(2, 0, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h40, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h40, 4'hE, 1, 0);
        add(1, 1, 0, 0, 16'h0000, 7'h40, 4'hF, 1, 0);
        add(3, 1, 0, 0, 16'h0000, 7'h40, 4'hD, 1, 0);

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 7'h7F, 4'hF, 1'b1, 1'b0);
        #2 reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                cyc($sformatf("vec%0d.%0d", i, r), tbl[i].en, tbl[i].lz, tbl[i].lv,
                    tbl[i].data, tbl[i].seg, tbl[i].dig, tbl[i].rdy, tbl[i].fs);
            end
        end

        // Asynchronous reset mid-scan blanks the outputs before any clock edge
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", 7'h7F, 4'hF, 1'b1, 1'b0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        // Display and pending were lost: enable alone shows nothing
        cyc("post_reset0", 1, 0, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        cyc("post_reset1", 1, 0, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        cyc("post_reset2", 1, 0, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);

        // Load while disabled commits in BLANK; enabling then shows digit 0
        cyc("blank_load",   0, 1, 1, 16'h00A5, 7'h7F, 4'hF, 0, 0);
        cyc("blank_commit", 0, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        cyc("a5_entry",     1, 1, 0, 16'h0000, 7'h12, 4'hF, 1, 0);
        cyc("a5_d0_on",     1, 1, 0, 16'h0000, 7'h12, 4'hE, 1, 0);
        cyc("a5_d0_hold1",  1, 1, 0, 16'h0000, 7'h12, 4'hE, 1, 0);
        cyc("a5_d0_hold2",  1, 1, 0, 16'h0000, 7'h12, 4'hE, 1, 0);
        cyc("a5_d1_guard",  1, 1, 0, 16'h0000, 7'h08, 4'hF, 1, 0);
        cyc("a5_d1_on",     1, 1, 0, 16'h0000, 7'h08, 4'hD, 1, 0);

        // Pending load survives a disable and commits once blanked
        cyc("pend_load",    1, 1, 1, 16'h0003, 7'h08, 4'hD, 0, 0);
        cyc("pend_disable", 0, 1, 0, 16'h0000, 7'h7F, 4'hF, 0, 0);
        cyc("pend_commit",  0, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);
        cyc("pend_entry",   1, 1, 0, 16'h0000, 7'h30, 4'hF, 1, 0);
        cyc("pend_d0_on",   1, 1, 0, 16'h0000, 7'h30, 4'hE, 1, 0);
        cyc("pend_d0_h1",   1, 1, 0, 16'h0000, 7'h30, 4'hE, 1, 0);
        cyc("pend_d0_h2",   1, 1, 0, 16'h0000, 7'h30, 4'hE, 1, 0);
        cyc("pend_d1_lz",   1, 1, 0, 16'h0000, 7'h7F, 4'hF, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_encoder.md
Name: seg7_scan_encoder

Overview:
- Transmit-side counterpart of the 7-segment decoder: takes hex digits and drives a multiplexed, active-low 7-segment display.
- Encodes each 4-bit nibble to segments {g,f,e,d,c,b,a}. It scans NUM_DIGITS digits round-robin with a programmable dwell time.
- New display values are loaded through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- PRESCALE, 1000, clock cycles per digit dwell (>=2).
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan display; 0 = blank display.
- lz_en  input  1  leading-zero suppression enable.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_data  input  4*NUM_DIGITS  digit i = load_data[4i+3:4i]; digit 0 is least significant.
- seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
- dig_n  output  NUM_DIGITS  active-low one-hot digit select, registered.
- frame_start  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (async assert, sync release):
  - seg_n=7'h7F, dig_n=all ones, load_ready=1, frame_start=0.
  - State=BLANK; cnt=0, idx=0; display and pending registers cleared, pend_v=0.
- Handshake:
  - A transfer occurs when load_valid & load_ready. load_data is captured into pending, pend_v=1, load_ready=0 the next cycle.
  - load_data is ignored when load_ready=0.
  - load_ready returns to 1 the cycle after pending commits to display.
- Encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - blank=1111111.
- FSM states: BLANK, SCAN.
  - BLANK: seg_n=7F, dig_n=all ones, cnt=0, idx=0.
    - If pend_v, commit pending to display in the same cycle; load_ready is 1 the next cycle.
    - If enable=1 and display has been loaded at least once since reset, go to SCAN.
    - Entry to SCAN loads cnt=0, idx=0, seg_n=enc(digit 0), dig_n=all ones.
  - SCAN: cnt increments every cycle.
    - At cnt==PRESCALE-1: cnt<=0; idx<=idx+1, wrapping NUM_DIGITS-1 to 0; seg_n<=enc(new digit); dig_n<=all ones (guard cycle).
    - At cnt==0: dig_n<=~(1<<idx), held until the next guard.
    - Guard cycle = exactly 1 blank cycle per digit change, for anti-ghosting.
    - On the wrap to idx=0: frame_start pulses 1 cycle, coincident with the guard cycle. If pend_v, display<=pending in the same edge and seg_n uses the new digit 0.
    - enable=0 in any cycle: go to BLANK the next cycle; outputs blank that cycle; pending is retained.
- Simultaneous events:
  - A load accepted on the wrap edge goes to pending and commits at the next wrap, never bypassing into the current frame.
  - A load accepted in BLANK commits after one cycle.
- Leading-zero suppression (lz_en=1): digit i>0 shows blank if it and all higher digits are 0. Digit 0 always displays. lz_en is sampled combinationally at encode time.
- Latency: a load in SCAN appears on seg_n no later than NUM_DIGITS*PRESCALE cycles after acceptance.
- A reset assertion mid-operation blanks outputs immediately (async), and both pending and display are lost.

Test Plan:
- Reset → seg_n=7F, dig_n=4'hF, load_ready=1, frame_start=0. Hold enable=1 with no load → stays blank.
- NUM_DIGITS=4, PRESCALE=4. Load 16'h4321, enable=1 → 1-cycle guard per digit with seg_n 1111001 (1) → 0100100 (2) → 0110000 (3) → 0011001 (4). dig_n sequence E,D,B,7 with F guards. frame_start every 16 cycles.
- While scanning 4321, load 16'h8888 mid-frame → load_ready=0 until wrap; no mixed frame; the next frame shows 0000000 on all digits. A second load_valid while load_ready=0 is ignored.
- lz_en=1, load 16'h0050 → digits 3,2 blank (7F); digit 1=0010010; digit 0=1000000. Load 16'h0000 → only digit 0 is lit.
- Deassert enable mid-digit → next cycle seg_n=7F, dig_n=F. Reassert → scan restarts at digit 0, cnt=0.
- Assert reset_n=0 mid-scan → outputs blank asynchronously. After release, no display until a new load.
